// File: rtl/bg_fb_writer_if.sv
// ---------------------------------------------------------------------------
// bg_fb_writer_if
// Purpose : bundles the pixel input stream and the background index RAM
//           write port of bg_fb_writer.
// Signals : pix_valid / pix_idx / pix_ready  palette index stream
//           wr_en / wr_addr / wr_data         RAM write port
// Modports: master - pixel producer and RAM side (drives the stream,
//                    observes the write port)
//           slave  - bg_fb_writer (accepts the stream, drives the write port)
// Handshake: a pixel moves on every rising CLK edge where pix_valid and
//           pix_ready are both 1. The producer holds pix_idx stable while
//           pix_valid is 1 and may raise or drop pix_valid on any cycle;
//           pix_ready does not depend on pix_valid.
// ---------------------------------------------------------------------------
interface bg_fb_writer_if #(
   parameter int IDX_W  = 4,
   parameter int ADDR_W = 19
);
   logic              pix_valid;
   logic [IDX_W-1:0]  pix_idx;
   logic              pix_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [IDX_W-1:0]  wr_data;

   modport master (
      output pix_valid,
      output pix_idx,
      input  pix_ready,
      input  wr_en,
      input  wr_addr,
      input  wr_data
   );

   modport slave (
      input  pix_valid,
      input  pix_idx,
      output pix_ready,
      output wr_en,
      output wr_addr,
      output wr_data
   );
endinterface

// File: rtl/bg_fb_writer.sv
// ---------------------------------------------------------------------------
// bg_fb_writer
// Purpose : write side of the palette-indexed background store. Takes a
//           stream of palette indices and writes them row-major into the
//           background index RAM, either a whole frame or a band of rows
//           that wraps from the bottom row back to row 0.
// Ports   : CLK        system clock
//           RESET_N    asynchronous active-low reset
//           start      pulse, begins a fill (only looked at while idle)
//           start_row  first row to write
//           num_rows   rows to write, 0 means a full frame
//           abort      pulse, stops a fill in progress without done
//           fb         pixel stream + RAM write port (slave modport)
//           busy       fill in progress
//           done       one-cycle pulse, fill completed
//           err        one-cycle pulse, start rejected (start_row >= V_PIX)
//           state_dbg  current FSM state (0 idle, 1 write, 2 fin)
// ---------------------------------------------------------------------------
module bg_fb_writer #(
   parameter int H_PIX  = 640,
   parameter int V_PIX  = 480,
   parameter int IDX_W  = 4,
   parameter int ADDR_W = 19
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                start,
   input  logic [9:0]          start_row,
   input  logic [9:0]          num_rows,
   input  logic                abort,
   bg_fb_writer_if.slave       fb,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [1:0]          state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      FIN   = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIX * V_PIX - 1);
   localparam logic [9:0]        V_PIX_R   = 10'(V_PIX);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] pixels_left;
   logic [ADDR_W-1:0] row_base;
   logic [ADDR_W-1:0] fill_len;
   logic [9:0]        rows_eff;
   logic              xfer;
   logic              start_ok;
   logic              start_bad;

   assign xfer      = fb.pix_valid & fb.pix_ready;
   assign start_ok  = (state == IDLE) & start & (start_row <  V_PIX_R);
   assign start_bad = (state == IDLE) & start & (start_row >= V_PIX_R);

   // Oversized band requests are clipped to one frame.
   assign rows_eff = ((num_rows == 10'd0) || (num_rows > V_PIX_R)) ? V_PIX_R : num_rows;

   // Row-to-pixel scaling. The standard 640-pixel row is built from two
   // shifts (640 = 512 + 128) so no multiplier is needed.
   generate
      if (H_PIX == 640) begin : g_mul640
         assign row_base = (ADDR_W'(start_row) << 9) + (ADDR_W'(start_row) << 7);
         assign fill_len = (ADDR_W'(rows_eff)  << 9) + (ADDR_W'(rows_eff)  << 7);
      end else begin : g_mul
         assign row_base = ADDR_W'(start_row) * ADDR_W'(H_PIX);
         assign fill_len = ADDR_W'(rows_eff)  * ADDR_W'(H_PIX);
      end
   endgenerate

   // State register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic. Abort beats a simultaneous last transfer.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start_ok) state_nx = WRITE;
         WRITE: begin
            if (abort) begin
               state_nx = IDLE;
            end else if (xfer && (pixels_left == ADDR_W'(1))) begin
               state_nx = FIN;
            end
         end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      fb.pix_ready = (state == WRITE);
      busy         = (state != IDLE);
      done         = (state == FIN);
      state_dbg    = state;
   end

   // Datapath: the write port is registered, so each accepted pixel appears
   // on wr_* the cycle after its transfer. A transfer in an abort cycle is
   // therefore still written, one cycle after the FSM has returned to IDLE.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         addr        <= '0;
         pixels_left <= '0;
         fb.wr_en    <= 1'b0;
         fb.wr_addr  <= '0;
         fb.wr_data  <= '0;
         err         <= 1'b0;
      end else begin
         fb.wr_en <= xfer;
         err      <= start_bad;
         if (start_ok) begin
            addr        <= row_base;
            pixels_left <= fill_len;
         end else if (xfer) begin
            fb.wr_addr  <= addr;
            fb.wr_data  <= fb.pix_idx;
            // Past the last pixel of the bottom row the band wraps to row 0.
            addr        <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
            pixels_left <= pixels_left - ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bg_fb_writer.sv
// ---------------------------------------------------------------------------
// tb_bg_fb_writer
// Two writers share one stimulus bus: a reduced 16x12 frame for long and
// random fills, and the full 640x480 frame for the wrap at row 479 and the
// shift-add row scaling. sel chooses which one is started and observed.
// Expected writes are derived from row/column arithmetic on the transfer
// index and kept in a queue that the write monitor drains.
// ---------------------------------------------------------------------------
module tb_bg_fb_writer;

   localparam int S_H  = 16;
   localparam int S_V  = 12;
   localparam int S_AW = 8;
   localparam int L_H  = 640;
   localparam int L_V  = 480;
   localparam int L_AW = 19;
   localparam int IW   = 4;

   // ---------------- clock / reset ----------------
   logic CLK     = 1'b0;
   logic RESET_N = 1'b0;
   always #5 CLK = ~CLK;

   logic          start     = 1'b0;
   logic          abort     = 1'b0;
   logic          pix_valid = 1'b0;
   logic          sel       = 1'b0;
   logic [9:0]    start_row = '0;
   logic [9:0]    num_rows  = '0;
   logic [IW-1:0] pix_idx   = '0;

   bg_fb_writer_if #(.IDX_W(IW), .ADDR_W(S_AW)) if_s ();
   bg_fb_writer_if #(.IDX_W(IW), .ADDR_W(L_AW)) if_l ();

   assign if_s.pix_valid = pix_valid & ~sel;
   assign if_s.pix_idx   = pix_idx;
   assign if_l.pix_valid = pix_valid & sel;
   assign if_l.pix_idx   = pix_idx;

   logic       busy_s, done_s, err_s, busy_l, done_l, err_l;
   logic [1:0] st_s, st_l;

   bg_fb_writer #(.H_PIX(S_H), .V_PIX(S_V), .IDX_W(IW), .ADDR_W(S_AW)) u_dut_s (
      .CLK(CLK), .RESET_N(RESET_N), .start(start & ~sel), .start_row(start_row),
      .num_rows(num_rows), .abort(abort & ~sel), .fb(if_s.slave),
      .busy(busy_s), .done(done_s), .err(err_s), .state_dbg(st_s));

   bg_fb_writer #(.H_PIX(L_H), .V_PIX(L_V), .IDX_W(IW), .ADDR_W(L_AW)) u_dut_l (
      .CLK(CLK), .RESET_N(RESET_N), .start(start & sel), .start_row(start_row),
      .num_rows(num_rows), .abort(abort & sel), .fb(if_l.slave),
      .busy(busy_l), .done(done_l), .err(err_l), .state_dbg(st_l));

   // Observed signals of the selected writer
   logic          m_ready, m_wr_en, m_busy, m_done, m_err;
   logic [31:0]   m_addr;
   logic [IW-1:0] m_data;
   logic [1:0]    m_st;
   always_comb begin
      if (sel) begin
         m_ready = if_l.pix_ready; m_wr_en = if_l.wr_en; m_busy = busy_l;
         m_done  = done_l; m_err = err_l; m_addr = 32'(if_l.wr_addr);
         m_data  = if_l.wr_data; m_st = st_l;
      end else begin
         m_ready = if_s.pix_ready; m_wr_en = if_s.wr_en; m_busy = busy_s;
         m_done  = done_s; m_err = err_s; m_addr = 32'(if_s.wr_addr);
         m_data  = if_s.wr_data; m_st = st_s;
      end
   end

   // ---------------- scoreboard ----------------
   logic [35:0] exp_q[$];   // {data, addr}
   int tests_run = 0;
   int fails     = 0;
   int wr_cnt, done_cnt, first_addr, last_addr;
   int h_cur = S_H;
   int v_cur = S_V;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests_run++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic int rows_eff(input int n, input int v);
      return (n == 0 || n > v) ? v : n;
   endfunction

   // Address of the kk-th pixel of a fill starting at row: row-major with
   // the row index taken modulo the frame height.
   function automatic logic [31:0] model_addr(input int row, input int kk);
      return 32'(((row + kk / h_cur) % v_cur) * h_cur + kk % h_cur);
   endfunction

   always @(negedge CLK) begin
      if (RESET_N) begin
         if (m_wr_en) begin
            if (exp_q.size() == 0) begin
               check("wr_unexpected", 1, 0);
            end else begin
               logic [35:0] e;
               e = exp_q.pop_front();
               check("wr_addr", m_addr, e[31:0]);
               check("wr_data", m_data, e[35:32]);
            end
            if (wr_cnt == 0) first_addr = int'(m_addr);
            last_addr = int'(m_addr);
            wr_cnt++;
         end
         if (m_done) begin
            done_cnt++;
            check("done_with_last_wr", {m_wr_en, m_busy, exp_q.size() == 0}, 3'b111);
         end
         if (sel ? if_s.wr_en : if_l.wr_en) check("unselected_wr", 1, 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start(input int row, input int nrows);
      @(negedge CLK);
      start     = 1'b1;
      start_row = 10'(row);
      num_rows  = 10'(nrows);
      @(negedge CLK);
      start     = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, {if_s.pix_ready, if_l.pix_ready}, 0);
      check({tag, "_wr_en"}, {if_s.wr_en, if_l.wr_en}, 0);
      check({tag, "_busy_done_err"}, {busy_s, done_s, err_s, busy_l, done_l, err_l}, 0);
      check({tag, "_state"}, {st_s, st_l}, 0);
      check({tag, "_addr_data"}, {if_s.wr_addr, if_s.wr_data, if_l.wr_addr, if_l.wr_data}, 0);
   endtask

   // One fill. abort_at / restart_at / reset_at (>=0) act when that many
   // transfers have been made.
   task automatic run_fill(input int row, input int nrows, input int pct,
                           input int abort_at, input int restart_at, input int reset_at);
      int  total, k, cyc, budget;
      bit  stop, v;
      wr_cnt = 0; done_cnt = 0; first_addr = -1; last_addr = -1;
      k = 0; cyc = 0; stop = 1'b0;
      total  = rows_eff(nrows, v_cur) * h_cur;
      budget = total * 8 + 100;
      pulse_start(row, nrows);
      check("start_err", m_err, row >= v_cur);
      check("start_busy", m_busy, row < v_cur);
      if (row >= v_cur) begin
         @(negedge CLK);
         check("err_one_cycle", {m_err, m_busy}, 0);
      end else begin
         while (k < total && !stop && cyc < budget) begin
            if (reset_at >= 0 && k == reset_at) begin
               RESET_N   = 1'b0;
               pix_valid = 1'b0;
               #1;
               check_reset_outputs("mid_reset");
               exp_q.delete();
               repeat (2) @(negedge CLK);
               RESET_N = 1'b1;
               stop    = 1'b1;
            end else begin
               v         = ($urandom_range(99) < pct);
               pix_valid = v;
               pix_idx   = IW'($urandom);
               abort     = (abort_at >= 0 && k == abort_at);
               start     = (restart_at >= 0 && k == restart_at);
               if (start) begin
                  start_row = 10'd5;
                  num_rows  = 10'd1;
               end
               if (abort) stop = 1'b1;
               if (v && m_ready) begin
                  exp_q.push_back({pix_idx, model_addr(row, k)});
                  k++;
               end
               @(negedge CLK);
               cyc++;
            end
         end
         pix_valid = 1'b0; abort = 1'b0; start = 1'b0;
         if (cyc >= budget) check("fill_timeout", 1, 0);
      end
      repeat (3) @(negedge CLK);
      check("idle_after_fill", {m_busy, m_ready}, 0);
      check("queue_drained", exp_q.size(), 0);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      int row;
      int nrows;
      int pct;
      int exp_writes;
      int exp_first;
      int exp_last;
      int exp_done;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0,   0,  100, 192, 0,   191, 1};   // full frame
      vecs[1] = '{10,  3,  100, 48,  160, 15,  1};   // band wraps to row 0
      vecs[2] = '{3,   1,  50,  16,  48,  63,  1};   // one row, 50% valid
      vecs[3] = '{12,  1,  100, 0,   -1,  -1,  0};   // start_row == V: err
      vecs[4] = '{500, 2,  100, 0,   -1,  -1,  0};   // start_row far out: err
      vecs[5] = '{0,   13, 100, 192, 0,   191, 1};   // num_rows clipped to V
      vecs[6] = '{11,  12, 70,  192, 176, 175, 1};   // full frame from last row
      vecs[7] = '{5,   0,  30,  192, 80,  79,  1};   // full frame, sparse valid
      vecs[8] = '{11,  1,  60,  16,  176, 191, 1};   // bottom row only

      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge CLK);
      RESET_N = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 9; i++) begin
         run_fill(vecs[i].row, vecs[i].nrows, vecs[i].pct, -1, -1, -1);
         check($sformatf("v%0d_writes", i), wr_cnt, vecs[i].exp_writes);
         check($sformatf("v%0d_first", i), first_addr, vecs[i].exp_first);
         check($sformatf("v%0d_last", i), last_addr, vecs[i].exp_last);
         check($sformatf("v%0d_done", i), done_cnt, vecs[i].exp_done);
      end

      // Abort after 100 pixels: pixel in the abort cycle is still written.
      run_fill(0, 0, 100, 100, -1, -1);
      check("abort_writes", wr_cnt, 101);
      check("abort_no_done", done_cnt, 0);

      // Reset at pixel 50 of a new fill, then a normal fill.
      run_fill(0, 0, 100, -1, -1, 50);
      check("reset_no_done", done_cnt, 0);
      run_fill(2, 2, 100, -1, -1, -1);
      check("post_reset_writes", wr_cnt, 32);
      check("post_reset_first", first_addr, 32);
      check("post_reset_last", last_addr, 63);
      check("post_reset_done", done_cnt, 1);

      // start with start_row=5 while busy is ignored.
      run_fill(1, 2, 100, -1, 10, -1);
      check("busy_start_writes", wr_cnt, 32);
      check("busy_start_first", first_addr, 16);
      check("busy_start_last", last_addr, 47);
      check("busy_start_done", done_cnt, 1);

      // Random fills against the model.
      for (int i = 0; i < 6; i++) begin
         int r, n, p, tot;
         r   = $urandom_range(S_V - 1);
         n   = $urandom_range(S_V + 2);
         p   = $urandom_range(100, 20);
         tot = rows_eff(n, S_V) * S_H;
         run_fill(r, n, p, -1, -1, -1);
         check("rand_writes", wr_cnt, tot);
         check("rand_first", first_addr, model_addr(r, 0));
         check("rand_last", last_addr, model_addr(r, tot - 1));
         check("rand_done", done_cnt, 1);
      end

      // Full-size frame: wrap at row 479 and shift-add row scaling.
      @(negedge CLK);
      sel = 1'b1; h_cur = L_H; v_cur = L_V;
      run_fill(478, 3, 100, -1, -1, -1);
      check("big_wrap_writes", wr_cnt, 1920);
      check("big_wrap_first", first_addr, 305920);
      check("big_wrap_last", last_addr, 639);
      check("big_wrap_done", done_cnt, 1);
      run_fill(1, 1, 50, -1, -1, -1);
      check("big_row1_writes", wr_cnt, 640);
      check("big_row1_first", first_addr, 640);
      check("big_row1_last", last_addr, 1279);
      run_fill(480, 1, 100, -1, -1, -1);
      check("big_err_writes", wr_cnt, 0);
      check("big_err_done", done_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
